// File: rtl/turn_controller.sv
// Tic-tac-toe turn sequencer: takes cell selections, strobes moves into the board register,
// reads the board back to detect win/draw, alternates players and auto-plays on timeout.
module turn_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 750_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      sel_pos,
    input  logic            confirm,
    input  logic [8:0][1:0] matriz,
    output logic [3:0]      pos,
    output logic            jugador,
    output logic            boton,
    output logic            board_rst,
    output logic [1:0]      winner,
    output logic            game_over
);

    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] StClear    = 3'd0;
    localparam logic [2:0] StWaitMove = 3'd1;
    localparam logic [2:0] StWrite    = 3'd2;
    localparam logic [2:0] StSettle   = 3'd3;
    localparam logic [2:0] StCheck    = 3'd4;
    localparam logic [2:0] StDone     = 3'd5;

    localparam logic [1:0] CellEmpty = 2'b00;
    localparam logic [1:0] CellX     = 2'b01;
    localparam logic [1:0] CellO     = 2'b10;

    localparam logic [1:0] WinNone = 2'b00;
    localparam logic [1:0] WinX    = 2'b01;
    localparam logic [1:0] WinO    = 2'b10;
    localparam logic [1:0] WinDraw = 2'b11;

    // Each nibble is a cell index; one 12-bit entry per winning line.
    localparam logic [7:0][2:0][3:0] Lines = {
        12'h246, 12'h048, 12'h258, 12'h147,
        12'h036, 12'h678, 12'h345, 12'h012
    };

    logic [2:0]        state_q, state_d;
    logic [3:0]        pos_q, pos_d;
    logic              jugador_q, jugador_d;
    logic              boton_q, boton_d;
    logic              board_rst_q, board_rst_d;
    logic [1:0]        winner_q, winner_d;
    logic              game_over_q, game_over_d;
    logic [TimerW-1:0] timer_q, timer_d;

    logic       x_win;
    logic       o_win;
    logic       any_empty;
    logic       sel_free;
    logic [3:0] lowest_empty;
    logic       timed_out;

    function automatic logic line_owned(input logic [8:0][1:0] board,
                                        input logic [2:0][3:0] idx,
                                        input logic [1:0]      mark);
        line_owned = (board[idx[0]] == mark) && (board[idx[1]] == mark) &&
                     (board[idx[2]] == mark);
    endfunction

    always_comb begin
        x_win = 1'b0;
        o_win = 1'b0;
        for (int l = 0; l < 8; l++) begin
            x_win = x_win | line_owned(matriz, Lines[l], CellX);
            o_win = o_win | line_owned(matriz, Lines[l], CellO);
        end
    end

    // Scan downwards so the last assignment wins and leaves the lowest empty index.
    always_comb begin
        any_empty    = 1'b0;
        sel_free     = 1'b0;
        lowest_empty = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (matriz[i] == CellEmpty) begin
                any_empty    = 1'b1;
                lowest_empty = 4'(i);
                if (sel_pos == 4'(i)) begin
                    sel_free = 1'b1;
                end
            end
        end
    end

    assign timed_out = (timer_q == TimerLast);

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        jugador_d   = jugador_q;
        boton_d     = 1'b0;
        board_rst_d = 1'b0;
        winner_d    = winner_q;
        game_over_d = game_over_q;
        timer_d     = timer_q;

        case (state_q)
            StClear: begin
                jugador_d   = 1'b1;
                winner_d    = WinNone;
                game_over_d = 1'b0;
                timer_d     = '0;
                state_d     = StWaitMove;
            end

            StWaitMove: begin
                if (!timed_out) begin
                    timer_d = timer_q + TimerW'(1);
                end
                // A legal confirm takes priority over an expiring timer.
                if (confirm && sel_free) begin
                    pos_d   = sel_pos;
                    boton_d = 1'b1;
                    state_d = StWrite;
                end else if (timed_out && any_empty) begin
                    pos_d   = lowest_empty;
                    boton_d = 1'b1;
                    state_d = StWrite;
                end
            end

            StWrite: begin
                state_d = StSettle;
            end

            StSettle: begin
                state_d = StCheck;
            end

            StCheck: begin
                if (x_win) begin
                    winner_d    = WinX;
                    game_over_d = 1'b1;
                    state_d     = StDone;
                end else if (o_win) begin
                    winner_d    = WinO;
                    game_over_d = 1'b1;
                    state_d     = StDone;
                end else if (!any_empty) begin
                    winner_d    = WinDraw;
                    game_over_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    jugador_d = ~jugador_q;
                    timer_d   = '0;
                    state_d   = StWaitMove;
                end
            end

            StDone: begin
                if (confirm) begin
                    board_rst_d = 1'b1;
                    game_over_d = 1'b0;
                    state_d     = StClear;
                end
            end

            default: begin
                board_rst_d = 1'b1;
                state_d     = StClear;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StClear;
            pos_q       <= 4'd0;
            jugador_q   <= 1'b1;
            boton_q     <= 1'b0;
            board_rst_q <= 1'b1;
            winner_q    <= WinNone;
            game_over_q <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            jugador_q   <= jugador_d;
            boton_q     <= boton_d;
            board_rst_q <= board_rst_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
            timer_q     <= timer_d;
        end
    end

    assign pos       = pos_q;
    assign jugador   = jugador_q;
    assign boton     = boton_q;
    assign board_rst = board_rst_q;
    assign winner    = winner_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_turn_controller.sv
// Scoreboard bench for turn_controller: a game-level model predicts each board write and
// each game result with its cycle; a negedge monitor compares what the DUT presents.
module tb_turn_controller;

    localparam int unsigned To = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      sel_pos = 4'd0;
    logic            confirm = 1'b0;
    logic [8:0][1:0] matriz = '0;
    logic [3:0]      pos;
    logic            jugador;
    logic            boton;
    logic            board_rst;
    logic [1:0]      winner;
    logic            game_over;

    turn_controller #(.TIMEOUT_CYCLES(To)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel_pos   (sel_pos),
        .confirm   (confirm),
        .matriz    (matriz),
        .pos       (pos),
        .jugador   (jugador),
        .boton     (boton),
        .board_rst (board_rst),
        .winner    (winner),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Board register environment: writes the mark on a boton rising edge if the cell is empty.
    logic boton_seen = 1'b0;
    always @(posedge clk) begin
        boton_seen <= boton;
        if (board_rst === 1'b1) matriz <= '0;
        else if (boton === 1'b1 && boton_seen !== 1'b1 && pos <= 4'd8 && matriz[pos] == 2'b00)
            matriz[pos] <= jugador ? 2'b01 : 2'b10;
    end

    typedef struct {logic [3:0] pos; logic ply; int at;} wr_t;
    typedef struct {logic [1:0] win; int at;} end_t;
    wr_t  exp_wr[$];
    end_t exp_end[$];
    int   exp_clr[$];

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Game-level reference model.
    int ref_cell[9];
    bit ref_ply;
    bit ref_over;
    int wait_edges;
    localparam int WinLines[8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                                      '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

    function automatic void ref_reset();
        foreach (ref_cell[i]) ref_cell[i] = 0;
        ref_ply = 1'b1;
        ref_over = 1'b0;
        wait_edges = 0;
    endfunction

    function automatic logic [1:0] ref_outcome();
        for (int m = 1; m <= 2; m++)
            for (int l = 0; l < 8; l++)
                if (ref_cell[WinLines[l][0]] == m && ref_cell[WinLines[l][1]] == m &&
                    ref_cell[WinLines[l][2]] == m) return 2'(m);
        foreach (ref_cell[i]) if (ref_cell[i] == 0) return 2'b00;
        return 2'b11;
    endfunction

    function automatic int ref_lowest();
        for (int i = 0; i < 9; i++) if (ref_cell[i] == 0) return i;
        return 0;
    endfunction

    // Called before the deciding edge, so expectations are queued ahead of the DUT output.
    function automatic void model_move(input int p);
        logic [1:0] o;
        exp_wr.push_back('{pos: 4'(p), ply: ref_ply, at: cyc + 1});
        ref_cell[p] = ref_ply ? 1 : 2;
        o = ref_outcome();
        if (o != 2'b00) begin
            exp_end.push_back('{win: o, at: cyc + 4});
            ref_over = 1'b1;
        end else begin
            ref_ply = ~ref_ply;
        end
        wait_edges = 0;
    endfunction

    // kind: 0 nothing happened, 1 a move was made, 2 a new game was started
    task automatic drive_cycle(input bit c, input logic [3:0] s, output int kind);
        kind = 0;
        confirm = c;
        sel_pos = s;
        if (ref_over) begin
            if (c) begin
                exp_clr.push_back(cyc + 1);
                ref_reset();
                kind = 2;
            end
        end else if (c && s <= 4'd8 && ref_cell[int'(s)] == 0) begin
            model_move(int'(s));
            kind = 1;
        end else if (wait_edges == To - 1) begin
            model_move(ref_lowest());
            kind = 1;
        end else begin
            wait_edges++;
        end
        @(negedge clk);
        confirm = 1'b0;
    endtask

    task automatic step(input bit c, input logic [3:0] s);
        int k;
        drive_cycle(c, s, k);
        if (k == 1) repeat (3) @(negedge clk);
        else if (k == 2) @(negedge clk);
    endtask

    // Entries: cell/selection to confirm, or -1 to let the turn time out.
    task automatic run_script(input int sc[$]);
        int k;
        int guard;
        foreach (sc[i]) begin
            if (sc[i] < 0) begin
                guard = 0;
                do begin
                    drive_cycle(1'b0, 4'd0, k);
                    guard++;
                end while (k == 0 && guard < 40);
                if (k == 1) repeat (3) @(negedge clk);
            end else begin
                step(1'b1, 4'(sc[i]));
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        confirm = 1'b0;
        sel_pos = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_board_rst", board_rst, 1);
        chk("rst_jugador", jugador, 1);
        chk("rst_winner", winner, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_boton", boton, 0);
        chk("rst_pos", pos, 0);
        rst = 1'b0;
        ref_reset();
        @(negedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, a result or a clear.
    initial begin
        logic boton_prev = 1'b0;
        logic go_prev = 1'b0;
        logic brst_prev = 1'b0;
        bit   clr_follow = 1'b0;
        wr_t  w;
        end_t e;
        int   t;
        forever begin
            @(negedge clk);
            if (clr_follow) begin
                chk("clear_jugador", jugador, 1);
                chk("clear_winner", winner, 0);
                clr_follow = 1'b0;
            end
            if (boton_prev === 1'b1) chk("boton_width", boton, 0);
            if (boton === 1'b1 && boton_prev !== 1'b1) begin
                if (exp_wr.size() == 0) chk("boton_unexpected", boton, 0);
                else begin
                    w = exp_wr.pop_front();
                    chk("write_pos", pos, w.pos);
                    chk("write_jugador", jugador, w.ply);
                    chk("write_cycle", cyc, w.at);
                end
            end
            if (game_over === 1'b1 && go_prev === 1'b0) begin
                if (exp_end.size() == 0) chk("game_over_unexpected", game_over, 0);
                else begin
                    e = exp_end.pop_front();
                    chk("winner", winner, e.win);
                    chk("done_cycle", cyc, e.at);
                end
            end
            if (board_rst === 1'b1 && brst_prev === 1'b0 && rst === 1'b0) begin
                if (exp_clr.size() == 0) chk("board_rst_unexpected", board_rst, 0);
                else begin
                    t = exp_clr.pop_front();
                    chk("clear_cycle", cyc, t);
                    chk("clear_game_over", game_over, 0);
                    clr_follow = 1'b1;
                end
            end
            boton_prev = boton;
            go_prev = game_over;
            brst_prev = board_rst;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // First move, turn flip, then rejected confirms on an occupied cell and out of range.
        apply_reset();
        step(1'b1, 4'd4);
        chk("jugador_after_move", jugador, ref_ply);
        step(1'b1, 4'd4);
        step(1'b1, 4'd9);
        repeat (2) step(1'b0, 4'd0);
        chk("jugador_after_illegal", jugador, ref_ply);

        // X wins on the top row; DONE ignores time, next confirm starts a fresh game.
        apply_reset();
        run_script('{0, 3, 1, 4, 2});
        repeat (20) step(1'b0, 4'd0);
        chk("game_over_held", game_over, ref_over);
        step(1'b1, 4'd0);
        step(1'b1, 4'd8);

        // Auto-move to the lowest empty cell after a silent turn.
        apply_reset();
        run_script('{0, 1, 2, -1});

        // Full board with no line, then O on the 2-4-6 diagonal.
        apply_reset();
        run_script('{0, 1, 2, 4, 3, 5, 7, 6, 8});
        apply_reset();
        run_script('{0, 2, 1, 4, 5, 6});

        // Reset while the write strobe is high.
        apply_reset();
        drive_cycle(1'b1, 4'd4, k);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_boton", boton, 0);
        chk("midrst_board_rst", board_rst, 1);
        chk("midrst_jugador", jugador, 1);
        chk("midrst_winner", winner, 0);
        chk("midrst_game_over", game_over, 0);
        chk("midrst_pos", pos, 0);
        rst = 1'b0;
        ref_reset();
        @(negedge clk);

        // Random play, including illegal selections, timeouts and restarts from DONE.
        repeat (800) step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));

        repeat (6) @(negedge clk);
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_results", exp_end.size(), 0);
        chk("pending_clears", exp_clr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
